// File: rtl/fb_arb_pkg.sv
// fb_arb_pkg
//   Shared types and default constants for the frame-buffer port arbiter.
//   Contents:
//     fb_state_e        arbiter FSM state (IDLE, READ, WRITE, FORCE_WR)
//     FB_*_DEF          default values for ADDR_W, DATA_W, MEM_LAT, STARVE_MAX
package fb_arb_pkg;

    localparam int unsigned FB_ADDR_W_DEF     = 19;  // 640x480 = 307200 words
    localparam int unsigned FB_DATA_W_DEF     = 24;  // RGB888
    localparam int unsigned FB_MEM_LAT_DEF    = 2;
    localparam int unsigned FB_STARVE_MAX_DEF = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ     = 2'd1,
        WRITE    = 2'd2,
        FORCE_WR = 2'd3
    } fb_state_e;

endpackage

// File: rtl/fb_rd_valid_pipe.sv
// fb_rd_valid_pipe
//   MEM_LAT-deep valid delay line for the frame-buffer read return path.
//   The last stage marks the cycle in which rdata_i carries the pixel for a
//   read granted MEM_LAT cycles earlier; data_o passes rdata_i through in
//   that cycle and holds the last returned pixel otherwise.
//   Ports:
//     VGA_CLK, RESET   clock, synchronous active-high reset
//     vld_i            read granted this cycle
//     rdata_i          frame-buffer read data
//     vld_o            returned pixel valid
//     data_o           returned pixel
module fb_rd_valid_pipe
    import fb_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT = FB_MEM_LAT_DEF,
    parameter int unsigned DATA_W  = FB_DATA_W_DEF
) (
    input  logic              VGA_CLK,
    input  logic              RESET,
    input  logic              vld_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] data_o
);

    logic [MEM_LAT-1:0] vld_q;
    logic [DATA_W-1:0]  data_q;

    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q[0] <= vld_i;
            for (int i = 1; i < MEM_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            if (vld_q[MEM_LAT-1]) begin
                data_q <= rdata_i;
            end
        end
    end

    assign vld_o  = vld_q[MEM_LAT-1];
    // Pass-through in the valid cycle keeps the read latency at exactly MEM_LAT.
    assign data_o = vld_o ? rdata_i : data_q;

endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
//   Single-port frame-buffer arbiter between the display read stream and the
//   UDP-side pixel write stream. Grants are combinational from the requests
//   and registered state; the memory port is registered one cycle after the
//   grant. Read has priority (display deadline).
//   Build option: FB_PORT_ARBITER_STARVE_GUARD_EN adds a starve counter that
//   forces a pending write through after STARVE_MAX consecutive read grants.
//   Without it, reads have strict priority.
//   Ports:
//     VGA_CLK, RESET                 clock, synchronous active-high reset
//     rd_req_i, rd_addr_i            display read request / address
//     rd_gnt_o                       read accepted this cycle
//     rd_valid_o, rd_data_o          read return, MEM_LAT cycles after rd_gnt_o
//     wr_req_i, wr_addr_i, wr_data_i write request / address / pixel
//     wr_gnt_o                       write accepted this cycle
//     mem_en_o, mem_we_o             frame-buffer enable / write enable
//     mem_addr_o, mem_wdata_o        frame-buffer address / write data
//     mem_rdata_i                    frame-buffer read data
//
//   state    | meaning
//   ---------+-------------------------------------------
//   IDLE     | no grant last cycle
//   READ     | read granted last cycle
//   WRITE    | write granted last cycle (normal priority)
//   FORCE_WR | write granted last cycle by the starve guard
module fb_port_arbiter
    import fb_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = FB_ADDR_W_DEF,
    parameter int unsigned DATA_W     = FB_DATA_W_DEF,
    parameter int unsigned MEM_LAT    = FB_MEM_LAT_DEF,
    parameter int unsigned STARVE_MAX = FB_STARVE_MAX_DEF
) (
    input  logic              VGA_CLK,
    input  logic              RESET,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_gnt_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_gnt_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    if (MEM_LAT == 0 || MEM_LAT > 4 || STARVE_MAX == 0 || STARVE_MAX > 255) begin : g_param_check
        $error("fb_port_arbiter: MEM_LAT must be 1..4 and STARVE_MAX 1..255");
    end

    fb_state_e         state_q, state_d;
    logic              rd_gnt, wr_gnt, force_wr;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

`ifdef FB_PORT_ARBITER_STARVE_GUARD_EN
    localparam logic [7:0] STARVE_MAX_C = 8'(STARVE_MAX);

    logic [7:0] starve_q, starve_d;

    assign force_wr = wr_req_i && (starve_q == STARVE_MAX_C);

    always_comb begin
        starve_d = starve_q;
        if (!wr_req_i || wr_gnt) begin
            starve_d = '0;
        end else if (rd_gnt && (starve_q != STARVE_MAX_C)) begin
            starve_d = starve_q + 8'd1;
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_wr = 1'b0;
`endif

    // Grants are gated by RESET because they are combinational from the
    // requests, which the requesters may keep asserted through reset.
    always_comb begin
        rd_gnt      = 1'b0;
        wr_gnt      = 1'b0;
        state_d     = IDLE;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (!RESET) begin
            wr_gnt = wr_req_i && (!rd_req_i || force_wr);
            rd_gnt = rd_req_i && !wr_gnt;
        end
        if (wr_gnt) begin
            state_d     = force_wr ? FORCE_WR : WRITE;
            mem_addr_d  = wr_addr_i;
            mem_wdata_d = wr_data_i;
        end else if (rd_gnt) begin
            state_d    = READ;
            mem_addr_d = rd_addr_i;
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // The state records last cycle's grant, which is exactly this cycle's
    // memory access.
    assign mem_en_o    = (state_q != IDLE);
    assign mem_we_o    = (state_q == WRITE) || (state_q == FORCE_WR);
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign rd_gnt_o    = rd_gnt;
    assign wr_gnt_o    = wr_gnt;

    fb_rd_valid_pipe #(
        .MEM_LAT (MEM_LAT),
        .DATA_W  (DATA_W)
    ) u_rd_pipe (
        .VGA_CLK (VGA_CLK),
        .RESET   (RESET),
        .vld_i   (rd_gnt),
        .rdata_i (mem_rdata_i),
        .vld_o   (rd_valid_o),
        .data_o  (rd_data_o)
    );

endmodule

// File: tb/tb_fb_port_arbiter.sv
module tb_fb_port_arbiter;

    localparam int ADDR_W     = 19;
    localparam int DATA_W     = 24;
    localparam int MEM_LAT    = 2;   // environment memory below is one registered stage
    localparam int STARVE_MAX = 8;
`ifdef FB_PORT_ARBITER_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              VGA_CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              rd_req_i = 1'b0;
    logic [ADDR_W-1:0] rd_addr_i = '0;
    logic              rd_gnt_o;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_valid_o;
    logic              wr_req_i = 1'b0;
    logic [ADDR_W-1:0] wr_addr_i = '0;
    logic [DATA_W-1:0] wr_data_i = '0;
    logic              wr_gnt_o;
    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i = '0;

    fb_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .VGA_CLK(VGA_CLK), .RESET(RESET),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_gnt_o(rd_gnt_o),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_gnt_o(wr_gnt_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    int          n_cmp = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    bit          rst_edge = 1'b0;
    int          n_rd_gnt = 0, n_wr_gnt = 0, n_valid = 0;

    always @(posedge VGA_CLK) begin
        cyc      <= cyc + 1;
        rst_edge <= RESET;
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Initial frame-buffer content, distinct per address.
    function automatic logic [DATA_W-1:0] pat(int a);
        return DATA_W'((a * 32'h0001_0307) ^ 32'h00A5_5A3C);
    endfunction

    // Environment frame buffer: one registered read stage.
    logic [DATA_W-1:0] fb_mem [1024];
    bit                fb_seen [1024];
    always @(posedge VGA_CLK) begin
        if (mem_en_o) begin
            if (mem_we_o) begin
                fb_mem[mem_addr_o[9:0]]  <= mem_wdata_o;
                fb_seen[mem_addr_o[9:0]] <= 1'b1;
            end else begin
                mem_rdata_i <= fb_seen[mem_addr_o[9:0]] ? fb_mem[mem_addr_o[9:0]]
                                                        : pat(int'(mem_addr_o[9:0]));
            end
        end
    end

    // Reference model: frame-buffer contents in grant order plus arbitration rule.
    logic [DATA_W-1:0] ref_wr [int];
    function automatic logic [DATA_W-1:0] ref_rd(int a);
        if (ref_wr.exists(a)) return ref_wr[a];
        return pat(a);
    endfunction

    typedef struct {
        int unsigned       due;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_exp_t;
    typedef struct {
        int unsigned       due;
        logic [DATA_W-1:0] data;
    } rd_exp_t;

    mem_exp_t mq[$];
    rd_exp_t  vq[$];
    int       rd_streak = 0;   // reads granted in a row while a write waits

    always @(negedge VGA_CLK) begin
        bit exp_rd, exp_wr;
        if (RESET) begin
            mq.delete();
            vq.delete();
            rd_streak = 0;
            check("rst_rd_gnt", rd_gnt_o, 0);
            check("rst_wr_gnt", wr_gnt_o, 0);
            if (rst_edge) begin
                check("rst_rd_valid", rd_valid_o, 0);
                check("rst_mem_en", mem_en_o, 0);
                check("rst_mem_we", mem_we_o, 0);
                check("rst_mem_addr", mem_addr_o, 0);
                check("rst_mem_wdata", mem_wdata_o, 0);
                check("rst_rd_data", rd_data_o, 0);
            end
        end else begin
            exp_wr = wr_req_i && (!rd_req_i || (GUARD && rd_streak >= STARVE_MAX));
            exp_rd = rd_req_i && !exp_wr;
            check("rd_gnt", rd_gnt_o, exp_rd);
            check("wr_gnt", wr_gnt_o, exp_wr);
            check("gnt_excl", rd_gnt_o & wr_gnt_o, 0);
            if (rd_gnt_o) n_rd_gnt++;
            if (wr_gnt_o) n_wr_gnt++;
            if (exp_wr) begin
                ref_wr[int'(wr_addr_i)] = wr_data_i;
                mq.push_back('{cyc + 1, 1'b1, wr_addr_i, wr_data_i});
                rd_streak = 0;
            end
            if (exp_rd) begin
                mq.push_back('{cyc + 1, 1'b0, rd_addr_i, '0});
                vq.push_back('{cyc + MEM_LAT, ref_rd(int'(rd_addr_i))});
                if (wr_req_i) rd_streak++;
            end
            if (!wr_req_i) rd_streak = 0;
        end
    end

    // Monitor: pops expectations when the memory port / read return is due.
    initial begin
        mem_exp_t me;
        rd_exp_t  re;
        forever begin
            @(posedge VGA_CLK);
            #2;
            if (mq.size() > 0 && mq[0].due == cyc) begin
                me = mq.pop_front();
                check("mem_en", mem_en_o, 1);
                check("mem_we", mem_we_o, me.we);
                check("mem_addr", mem_addr_o, me.addr);
                if (me.we) check("mem_wdata", mem_wdata_o, me.data);
            end else if (mem_en_o) begin
                check("mem_en_unexpected", mem_en_o, 0);
            end
            if (rd_valid_o) n_valid++;
            if (vq.size() > 0 && vq[0].due == cyc) begin
                re = vq.pop_front();
                check("rd_valid", rd_valid_o, 1);
                check("rd_data", rd_data_o, re.data);
            end else if (rd_valid_o) begin
                check("rd_valid_unexpected", rd_valid_o, 0);
            end
        end
    end

    a_gnt_excl: assert property (@(posedge VGA_CLK) !(rd_gnt_o && wr_gnt_o))
        else begin
            n_fail++;
            $display("FAIL gnt_excl_assert: rd_gnt=1 wr_gnt=1, required at most one");
        end

    task automatic tick();
        @(posedge VGA_CLK);
        #1;
    endtask

    task automatic drive(bit rd, int ra, bit wr, int wa, int wd);
        rd_req_i  = rd;
        rd_addr_i = ADDR_W'(ra);
        wr_req_i  = wr;
        wr_addr_i = ADDR_W'(wa);
        wr_data_i = DATA_W'(wd);
        tick();
    endtask

    // Requesters hold an ungranted request (same address/data) until granted.
    task automatic run_traffic(int n, int p_rd, int p_wr, bit seq);
        bit rp = 1'b0;
        bit wp = 1'b0;
        int next_a = 0;
        for (int i = 0; i < n; i++) begin
            if (!rp && $urandom_range(99) < p_rd) begin
                rp = 1'b1;
                if (seq) begin
                    rd_addr_i = ADDR_W'(next_a);
                    next_a    = next_a + 1;
                end else begin
                    rd_addr_i = ADDR_W'($urandom_range(63));
                end
            end
            if (!wp && $urandom_range(99) < p_wr) begin
                wp        = 1'b1;
                wr_addr_i = ADDR_W'($urandom_range(63));
                wr_data_i = DATA_W'($urandom);
            end
            rd_req_i = rp;
            wr_req_i = wp;
            @(negedge VGA_CLK);
            if (rd_gnt_o) rp = 1'b0;
            if (wr_gnt_o) wp = 1'b0;
            tick();
        end
        rd_req_i = 1'b0;
        wr_req_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g_rd, g_wr, g_v;
        RESET = 1'b1;
        repeat (3) tick();
        RESET = 1'b0;
        repeat (2) tick();

        // Sequential reads 0..9, one per cycle.
        g_rd = n_rd_gnt; g_v = n_valid;
        run_traffic(10, 100, 0, 1'b1);
        repeat (MEM_LAT + 2) tick();
        check("seq_rd_gnt_count", n_rd_gnt - g_rd, 10);
        check("seq_rd_valid_count", n_valid - g_v, 10);

        // Single write, addr 100 data 0xFF0000.
        g_wr = n_wr_gnt;
        drive(1'b0, 0, 1'b1, 100, 24'hFF0000);
        drive(1'b0, 0, 1'b0, 0, 0);
        tick();
        check("single_wr_gnt_count", n_wr_gnt - g_wr, 1);

        // Both requests, then write only: read then write back to back.
        g_rd = n_rd_gnt; g_wr = n_wr_gnt;
        drive(1'b1, 5, 1'b1, 7, 24'h00ABCD);
        drive(1'b0, 0, 1'b1, 7, 24'h00ABCD);
        drive(1'b0, 0, 1'b0, 0, 0);
        repeat (MEM_LAT + 1) tick();
        check("b2b_rd_gnt_count", n_rd_gnt - g_rd, 1);
        check("b2b_wr_gnt_count", n_wr_gnt - g_wr, 1);

        // Both requests held high for 36 cycles.
        g_rd = n_rd_gnt; g_wr = n_wr_gnt;
        run_traffic(36, 100, 100, 1'b0);
        repeat (MEM_LAT + 2) tick();
        check("starve_wr_gnt_count", n_wr_gnt - g_wr, GUARD ? 4 : 0);
        check("starve_rd_gnt_count", n_rd_gnt - g_rd, GUARD ? 32 : 36);

        // Reset one cycle after a read grant: the read is discarded.
        g_v = n_valid;
        drive(1'b1, 3, 1'b0, 0, 0);
        RESET = 1'b1;
        drive(1'b1, 4, 1'b1, 9, 24'h123456);
        drive(1'b0, 0, 1'b0, 0, 0);
        RESET = 1'b0;
        repeat (5) tick();
        check("rst_discard_valid_count", n_valid - g_v, 0);

        // Randomised mixed traffic.
        run_traffic(400, 60, 50, 1'b0);
        repeat (MEM_LAT + 3) tick();
        check("drain_mem_queue", mq.size(), 0);
        check("drain_rd_queue", vq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
